// File: rtl/wb_arbiter.sv
// wb_arbiter: merges the unstallable ALU write path with a buffered mult/div path onto
// the register-file write port, squashing stale buffered writes and reporting RAW hazards.
module wb_arbiter #(
    parameter int DEPTH      = 2,
    parameter int MAX_STARVE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        md_valid,
    output logic        md_ready,
    input  logic [4:0]  md_rd,
    input  logic [31:0] md_data,
    input  logic [4:0]  query_rs,
    input  logic [4:0]  query_rt,
    output logic        pending_rs,
    output logic        pending_rt,
    output logic        stall_req,
    output logic        RegWrite,
    output logic [4:0]  WriteRegister,
    output logic [31:0] WriteData,
    output logic        err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = $clog2(MAX_STARVE + 1);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    localparam logic [SW-1:0] STARVE_LIMIT = SW'(MAX_STARVE);

    logic [4:0]       entRd   [DEPTH];
    logic [31:0]      entData [DEPTH];
    logic [DEPTH-1:0] entLive;
    logic [AW-1:0]    head, tail;
    logic [AW:0]      count;
    logic [SW-1:0]    starveCnt, starveInc;
    logic             aluReq, push, pop, nonEmpty, issueHead, anyLive;

    always_comb begin
        aluReq     = alu_valid && alu_rd != 5'd0;
        md_ready   = count < FULL;
        push       = md_valid && md_ready && md_rd != 5'd0;
        nonEmpty   = count != '0;
        issueHead  = !aluReq && entLive[head];
        pop        = !aluReq && nonEmpty;
        anyLive    = |entLive;
        starveInc  = starveCnt + 1'b1;
        pending_rs = 1'b0;
        pending_rt = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            pending_rs = pending_rs | (entLive[i] && entRd[i] == query_rs);
            pending_rt = pending_rt | (entLive[i] && entRd[i] == query_rt);
        end
        pending_rs = pending_rs && query_rs != 5'd0;
        pending_rt = pending_rt && query_rt != 5'd0;
    end

    // A slot's live bit is cleared on pop, so live always implies occupied.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            entLive       <= '0;
            starveCnt     <= '0;
            stall_req     <= 1'b0;
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
            err           <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                entRd[i]   <= '0;
                entData[i] <= '0;
            end
        end else begin
            RegWrite <= aluReq || issueHead;
            if (aluReq) begin
                WriteRegister <= alu_rd;
                WriteData     <= alu_data;
            end else if (issueHead) begin
                WriteRegister <= entRd[head];
                WriteData     <= entData[head];
            end
            err <= err || (aluReq && stall_req);
            for (int i = 0; i < DEPTH; i++)
                if (aluReq && entRd[i] == alu_rd) entLive[i] <= 1'b0;
            if (pop) begin
                entLive[head] <= 1'b0;
                head          <= head + 1'b1;
            end
            // The push lands after the squash, so a same-cycle entry stays live.
            if (push) begin
                entRd[tail]   <= md_rd;
                entData[tail] <= md_data;
                entLive[tail] <= 1'b1;
                tail          <= tail + 1'b1;
            end
            count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
            if (!nonEmpty || issueHead) begin
                starveCnt <= '0;
                stall_req <= 1'b0;
            end else if (aluReq && anyLive && starveInc == STARVE_LIMIT) begin
                starveCnt <= '0;
                stall_req <= 1'b1;
            end else begin
                if (aluReq && anyLive) starveCnt <= starveInc;
                stall_req <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed stimulus with a write-order scoreboard and a negedge monitor
// that checks every register-file write against the expected queue.
module tb_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        md_valid = 1'b0;
    logic        md_ready;
    logic [4:0]  md_rd = '0;
    logic [31:0] md_data = '0;
    logic [4:0]  query_rs = '0;
    logic [4:0]  query_rt = '0;
    logic        pending_rs, pending_rt, stall_req, RegWrite, err;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;

    int checks = 0;
    int errors = 0;
    logic [36:0] expQ[$];

    wb_arbiter #(.DEPTH(2), .MAX_STARVE(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd), .md_data(md_data),
        .query_rs(query_rs), .query_rt(query_rt),
        .pending_rs(pending_rs), .pending_rt(pending_rt), .stall_req(stall_req),
        .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
        .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && RegWrite) begin
            logic [36:0] e;
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL write: unexpected rd=%0d data=%h", WriteRegister, WriteData);
            end else begin
                e = expQ.pop_front();
                if ({WriteRegister, WriteData} !== e) begin
                    errors++;
                    $display("FAIL write: got rd=%0d data=%h, expected rd=%0d data=%h",
                             WriteRegister, WriteData, e[36:32], e[31:0]);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mr, input logic [31:0] mdat);
        alu_valid = av; alu_rd = ar; alu_data = ad;
        md_valid = mv; md_rd = mr; md_data = mdat;
    endtask

    task automatic idle();
        drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        #2;
        chk("reset RegWrite", 32'(RegWrite), 32'd0);
        chk("reset WriteRegister", 32'(WriteRegister), 32'd0);
        chk("reset WriteData", WriteData, 32'd0);
        chk("reset stall_req", 32'(stall_req), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        chk("reset md_ready", 32'(md_ready), 32'd1);
        #10 rst = 1'b0;
        tick();

        // ALU only, then rd=0 treated as no request
        drv(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
        expQ.push_back({5'd5, 32'h1234});
        tick();
        chk("alu RegWrite", 32'(RegWrite), 32'd1);
        drv(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'd0);
        tick();
        chk("alu rd0 RegWrite", 32'(RegWrite), 32'd0);

        // Fill buffer under a busy ALU, then drain
        drv(1'b1, 5'd1, 32'h1, 1'b1, 5'd8, 32'hA);
        expQ.push_back({5'd1, 32'h1});
        chk("fill ready0", 32'(md_ready), 32'd1);
        tick();
        drv(1'b1, 5'd2, 32'h2, 1'b1, 5'd9, 32'hB);
        expQ.push_back({5'd2, 32'h2});
        chk("fill ready1", 32'(md_ready), 32'd1);
        tick();
        drv(1'b1, 5'd3, 32'h3, 1'b0, 5'd0, 32'd0);
        expQ.push_back({5'd3, 32'h3});
        query_rs = 5'd9; query_rt = 5'd8;
        #1;
        chk("fill full md_ready", 32'(md_ready), 32'd0);
        chk("fill pending_rs 9", 32'(pending_rs), 32'd1);
        chk("fill pending_rt 8", 32'(pending_rt), 32'd1);
        tick();
        idle();
        expQ.push_back({5'd8, 32'hA});
        expQ.push_back({5'd9, 32'hB});
        tick();
        chk("drain1 RegWrite", 32'(RegWrite), 32'd1);
        chk("drain1 md_ready", 32'(md_ready), 32'd1);
        tick();
        chk("drain2 RegWrite", 32'(RegWrite), 32'd1);
        chk("drain2 pending_rs", 32'(pending_rs), 32'd0);

        // Squash: buffered rd12 overwritten by ALU, then dead pop
        drv(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hDEAD);
        query_rs = 5'd12; query_rt = 5'd0;
        tick();
        drv(1'b1, 5'd12, 32'hBEEF, 1'b0, 5'd0, 32'd0);
        expQ.push_back({5'd12, 32'hBEEF});
        #1;
        chk("squash pending before", 32'(pending_rs), 32'd1);
        tick();
        idle();
        #1;
        chk("squash pending after", 32'(pending_rs), 32'd0);
        tick();
        chk("dead pop RegWrite", 32'(RegWrite), 32'd0);
        // Same-cycle enqueue is younger than the ALU write and survives
        drv(1'b1, 5'd12, 32'h111, 1'b1, 5'd12, 32'h222);
        expQ.push_back({5'd12, 32'h111});
        expQ.push_back({5'd12, 32'h222});
        tick();
        idle();
        #1;
        chk("young entry pending", 32'(pending_rs), 32'd1);
        tick();
        chk("young entry RegWrite", 32'(RegWrite), 32'd1);

        // Starvation, honoured stall
        drv(1'b1, 5'd4, 32'h40, 1'b1, 5'd3, 32'h33);
        expQ.push_back({5'd4, 32'h40});
        tick();
        for (int k = 1; k <= 4; k++) begin
            drv(1'b1, 5'd4, 32'h40 + 32'(k), 1'b0, 5'd0, 32'd0);
            expQ.push_back({5'd4, 32'h40 + 32'(k)});
            tick();
            chk($sformatf("starve stall_req %0d", k), 32'(stall_req), (k == 4) ? 32'd1 : 32'd0);
        end
        idle();
        expQ.push_back({5'd3, 32'h33});
        tick();
        chk("stall released", 32'(stall_req), 32'd0);
        chk("stall head RegWrite", 32'(RegWrite), 32'd1);
        chk("no err after honoured stall", 32'(err), 32'd0);

        // Starvation, violated stall
        drv(1'b1, 5'd4, 32'h45, 1'b1, 5'd3, 32'h34);
        expQ.push_back({5'd4, 32'h45});
        tick();
        for (int k = 1; k <= 4; k++) begin
            drv(1'b1, 5'd4, 32'h45 + 32'(k), 1'b0, 5'd0, 32'd0);
            expQ.push_back({5'd4, 32'h45 + 32'(k)});
            tick();
        end
        chk("second stall_req", 32'(stall_req), 32'd1);
        drv(1'b1, 5'd4, 32'h50, 1'b0, 5'd0, 32'd0);
        expQ.push_back({5'd4, 32'h50});
        tick();
        chk("violation err", 32'(err), 32'd1);
        idle();
        expQ.push_back({5'd3, 32'h34});
        tick();
        tick();
        chk("err sticky", 32'(err), 32'd1);

        // Simultaneous push/pop, then wrap-around stream
        drv(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h66);
        expQ.push_back({5'd6, 32'h66});
        tick();
        drv(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77);
        expQ.push_back({5'd7, 32'h77});
        tick();
        idle();
        query_rs = 5'd7; query_rt = 5'd6;
        #1;
        chk("pushpop pending 7", 32'(pending_rs), 32'd1);
        chk("pushpop pending 6", 32'(pending_rt), 32'd0);
        chk("pushpop md_ready", 32'(md_ready), 32'd1);
        tick();
        chk("pushpop write 7", 32'(RegWrite), 32'd1);
        for (int k = 0; k < 5; k++) begin
            drv(1'b0, 5'd0, 32'd0, 1'b1, 5'(16 + k), 32'h100 + 32'(k));
            expQ.push_back({5'(16 + k), 32'h100 + 32'(k)});
            tick();
        end
        idle();
        tick();
        tick();

        // Async reset while draining two entries
        drv(1'b1, 5'd20, 32'h200, 1'b1, 5'd21, 32'h210);
        expQ.push_back({5'd20, 32'h200});
        tick();
        drv(1'b1, 5'd20, 32'h201, 1'b1, 5'd22, 32'h220);
        expQ.push_back({5'd20, 32'h201});
        tick();
        idle();
        expQ.push_back({5'd21, 32'h210});
        query_rs = 5'd22; query_rt = 5'd0;
        tick();
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("async rst RegWrite", 32'(RegWrite), 32'd0);
        chk("async rst md_ready", 32'(md_ready), 32'd1);
        chk("async rst pending", 32'(pending_rs), 32'd0);
        #1 rst = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("scoreboard drained", 32'(expQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Write-back arbiter that sits directly upstream of the 32x32 register file and drives its RegWrite/WriteRegister/WriteData inputs. Merges the in-order ALU/load result path, which cannot be stalled, with a variable-latency mult/div unit result path. Mult/div results are held in a small FIFO until the write port is free. Also reports pending mult/div destinations to decode so decode can stall on RAW hazards.

Parameters:
DEPTH, 2, mult/div result buffer entries (power of two, 2..8)
MAX_STARVE, 4, consecutive cycles a non-empty buffer is allowed to lose to the ALU before stall_req is raised

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
alu_valid  input  1  ALU-path write request this cycle
alu_rd  input  5  ALU-path destination register
alu_data  input  32  ALU-path write data
md_valid  input  1  mult/div result valid
md_ready  output  1  buffer can accept a mult/div result (combinational: count < DEPTH)
md_rd  input  5  mult/div destination register
md_data  input  32  mult/div result
query_rs  input  5  decode source register 1
query_rt  input  5  decode source register 2
pending_rs  output  1  a live buffered entry targets query_rs (combinational; 0 when query_rs = 0)
pending_rt  output  1  a live buffered entry targets query_rt (combinational; 0 when query_rt = 0)
stall_req  output  1  registered; requests upstream to hold alu_valid low this cycle
RegWrite  output  1  registered write enable to the register file
WriteRegister  output  5  registered write address
WriteData  output  32  registered write data
err  output  1  sticky protocol-violation flag

Behaviour:
- Reset (async): RegWrite=0, WriteRegister=0, WriteData=0, stall_req=0, err=0. Buffer is emptied (count=0, all entries not live), starve counter=0. md_ready=1 once count=0.
- Latency: a selected write appears on RegWrite/WriteRegister/WriteData on the clock edge after its request, so one cycle.
- Per-cycle selection, evaluated in this order:
  - alu_valid=1 and alu_rd!=0: issue the ALU write. The ALU has absolute priority.
  - Otherwise, if the head entry is live: issue the head and pop it.
  - Otherwise, if the head entry is dead (squashed): pop it silently with RegWrite=0. Dead heads still consume a cycle.
  - Otherwise: RegWrite=0, and WriteRegister/WriteData hold their previous values.
- rd=0 handling: an ALU request with alu_rd=0 is treated as no request. A mult/div handshake with md_rd=0 is accepted and discarded (nothing is enqueued).
- Enqueue: a handshake (md_valid & md_ready) pushes {rd, data, live=1} at the tail.
  - md_ready reflects the count at the start of the cycle, so a full buffer is not ready even when it pops in the same cycle.
  - Push and pop in the same cycle leave count unchanged.
  - Head/tail pointers wrap modulo DEPTH.
- Squash (program-order WAW): when an ALU write is issued, every live buffered entry with rd == alu_rd is marked dead in that same cycle.
  - A mult/div entry enqueued in the same cycle is not squashed; it is younger than the ALU write.
- Pending: pending_rs/pending_rt are the OR over live entries of (entry.rd == query). Dead entries do not count. Entries being popped in the current cycle still count.
- Starvation:
  - The starve counter increments each cycle the buffer holds a live entry and the ALU wins.
  - It clears when a buffered entry issues or the buffer is empty.
  - When the counter reaches MAX_STARVE, stall_req goes to 1 on the next edge for exactly one cycle, then the counter clears.
  - Upstream guarantees alu_valid=0 whenever stall_req=1, so the buffer head issues in that cycle.
- Protocol violation: alu_valid=1 with alu_rd!=0 while stall_req=1. The ALU still wins and is written. err sets to 1 and stays set until rst.
- Reset mid-operation: buffered writes are lost and any in-flight RegWrite is cleared immediately. No partial write is presented.

Test Plan:
- Reset, then ALU only: alu_valid=1, alu_rd=5, alu_data=0x1234 -> next cycle RegWrite=1, WriteRegister=5, WriteData=0x1234. A request with alu_rd=0 -> RegWrite=0.
- Mult/div fill: push rd=8 data=0xA, then rd=9 data=0xB while alu_valid=1 for 3 cycles -> md_ready=0 after 2 pushes, pending_rs=1 for query_rs=9. After the ALU idles, writes rd8=0xA then rd9=0xB on consecutive cycles and md_ready returns to 1.
- Squash: buffer holds rd=12 data=0xDEAD; ALU writes rd=12 data=0xBEEF -> register 12 receives only 0xBEEF. The next cycle, with the ALU idle, gives RegWrite=0 (dead pop), then count=0 and pending for 12 drops to 0.
- Starvation: buffer holds rd=3 while alu_valid=1 (rd=4) for 4 cycles -> stall_req=1 for one cycle. With alu_valid=0 in that cycle, the next cycle writes rd=3. A second run holds alu_valid=1 during stall_req -> the ALU write occurs and err=1 stays set.
- Simultaneous push/pop with count=1: md_valid with rd=7 while the head (rd=6) issues -> count stays 1, then rd=7 is written the next idle cycle. Repeat through pointer wrap-around over 5 pushes with data intact.
- Async reset mid-drain with 2 entries buffered: assert rst between edges -> RegWrite=0 immediately and md_ready=1. After release, no stale writes appear.
